uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: successor to the fixed 8N1 receiver.
//  - Samples an async serial line, deserialises LSB-first frames, checks optional parity and stop bits.
//  - Presents each frame through a one-entry valid/ready holding register with error and overrun flags.
//  - Sits between the board RX pin and the byte-stream consumer (command parser / FIFO).
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency, Hz
//  BAUD       115200       line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (868 at defaults), must be >= 4
//  DATA_BITS  8            payload bits per frame, legal 5..9
//  PARITY     0            0 none, 1 even, 2 odd
//  STOP_BITS  1            1 or 2
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  serial_in   in   1          async RX line, idle high
//  rx_data     out  DATA_BITS  received payload, bit 0 = first bit on line
//  rx_valid    out  1          rx_data and flags hold an unconsumed frame
//  rx_ready    in   1          consumer accepts frame when rx_valid && rx_ready
//  parity_err  out  1          parity mismatch for frame in rx_data (0 when PARITY=0)
//  frame_err   out  1          a stop bit sampled low for frame in rx_data
//  overrun     out  1          an unconsumed frame was overwritten
//  r_busy      out  1          high whenever FSM is not IDLE
// BEHAVIOUR
//  - Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, r_busy=0, FSM=IDLE, sync flops=1.
//  - serial_in passes a 2-flop synchroniser; all decisions use the synchronised value s (2-cycle delay).
//  - FSM states: IDLE, START, DATA, PARITY, STOP. Cycle counter width $clog2(CLKS_PER_BIT).
//  - IDLE: s==0 -> START, counter cleared.
//  - START: at count CLKS_PER_BIT/2-1 (mid start bit) sample s.
//      s==1 -> false start: return to IDLE, no output.
//      s==0 -> DATA, counter cleared.
//  - DATA/PARITY/STOP: sample s each time counter hits CLKS_PER_BIT-1 (mid-bit), then clear counter.
//  - DATA: shift s in at MSB, shifting right (LSB-first). After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
//  - PARITY: expected = ^payload (even) or ~^payload (odd); mismatch latches frame parity error.
//  - STOP: STOP_BITS samples; any low sample latches frame error.
//      After the last stop sample -> IDLE in the same cycle, so a start edge later in that stop bit is caught (back-to-back frames).
//  - Commit on cycle of last stop sample; outputs update next clock (1-cycle latency).
//      Loads rx_data, parity_err, frame_err; sets rx_valid. Frames with errors are still delivered.
//  - Handshake: rx_valid stays high, outputs stable, until rx_valid && rx_ready; then rx_valid=0 next cycle.
//  - Overrun/commit interaction:
//      Commit while rx_valid && !rx_ready: overwrite; set overrun.
//      Commit and handshake same cycle: load new frame, rx_valid stays 1, overrun unchanged.
//  - overrun is sticky; clears only on a handshake without a simultaneous overrun commit.
//  - Reset mid-frame: immediate return to reset values, partial frame discarded; next clean frame received normally.
//  - Counters never wrap: bit counter bounded by DATA_BITS / STOP_BITS, cycle counter cleared at CLKS_PER_BIT-1.
// STRUCTURE
//  - Shared package uart_pkg: FSM state enum, PARITY_NONE/EVEN/ODD constants, CLKS_PER_BIT computation function.
//    Also used by the future parametrised transmitter.
//  - One sub-module, uart_bit_timer: counter with mid-start and full-bit tick outputs plus clear input.
//    Reusable by the transmitter.
//  - Synchroniser, FSM, shift register and holding register stay in this module.
// TESTING
//  1. 8N1 defaults, rx_ready=1, send 0xA5 at 868 clk/bit
//     -> single-cycle rx_valid, rx_data=0xA5, parity_err=0, frame_err=0, overrun=0; r_busy low after stop.
//  2. 300-clk low glitch on serial_in -> no rx_valid; r_busy high about 436 clks, then 0.
//  3. PARITY=1, send 0x5A with parity bit 1 (wrong) -> rx_data=0x5A, parity_err=1; repeat with bit 0 -> parity_err=0.
//  4. Send 0x3C with stop bit driven low -> rx_data=0x3C, frame_err=1; following clean 0x3D -> frame_err=0.
//  5. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid held, rx_data=0x22, overrun=1.
//     Then rx_ready=1 for one cycle -> rx_valid=0, overrun=0 next cycle.
//  6. Assert reset during data bit 3 -> all outputs 0 while reset high; after release, 0xC3 received correctly.
//     Also run DATA_BITS=7, STOP_BITS=2, PARITY=2 with 0x55 -> rx_data=7'h55, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and baud timing.
// Also intended for the parametrised transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with mid-start and full-bit ticks.
// Wraps itself at the end of a bit; clear restarts from zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic mid_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || full_tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign mid_tick  = (cnt == MID);
  assign full_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a one-entry valid/ready holding register.
// Reports parity, framing and overrun conditions alongside each frame.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 r_busy
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

  rx_state_t            state, state_nx;
  logic [1:0]           sync;
  logic                 s;
  logic                 mid_tick, full_tick, tmr_clear;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q;
  logic                 last_data, last_stop;
  logic                 commit, handshake, par_exp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sync <= 2'b11;
    else
      sync <= {sync[0], serial_in};
  end

  assign s = sync[1];

  uart_bit_timer #(
    .CLKS_PER_BIT(CPB)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .mid_tick (mid_tick),
    .full_tick(full_tick)
  );

  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign commit    = (state == S_STOP) && full_tick && last_stop;
  assign handshake = rx_valid && rx_ready;
  assign par_exp   = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (!s) state_nx = S_START;
      S_START:
        if (mid_tick) state_nx = s ? S_IDLE : S_DATA;
      S_DATA:
        if (full_tick && last_data)
          state_nx = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY:
        if (full_tick) state_nx = S_STOP;
      S_STOP:
        if (full_tick && last_stop) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Timer restarts on the start edge and again at mid start bit,
  // so every later full tick lands in the middle of a bit.
  always_comb begin
    r_busy    = (state != S_IDLE);
    tmr_clear = (state == S_IDLE) || ((state == S_START) && mid_tick);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
        end
        S_DATA:
          if (full_tick) begin
            shreg   <= {s, shreg[DATA_BITS-1:1]};
            bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          end
        S_PARITY:
          if (full_tick) perr_q <= (s != par_exp);
        S_STOP:
          if (full_tick) begin
            if (!s) ferr_q <= 1'b1;
            bit_cnt <= last_stop ? 4'd0 : bit_cnt + 4'd1;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      rx_data    <= shreg;
      rx_valid   <= 1'b1;
      parity_err <= perr_q;
      frame_err  <= ferr_q | ~s;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (handshake) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1 default, fast 8E1 and fast 7O2.
// Stimulus pushes expected frames; per-instance monitors pop on handshake.
module tb_uart_rx_param;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk, rst;
  logic ser0, ser1, ser2;
  logic rdy0, rdy1, rdy2;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic val0, val1, val2;
  logic pe0, pe1, pe2, fe0, fe1, fe2;
  logic ov0, ov1, ov2, busy0, busy1, busy2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vcnt0    = 0;
  int   bcnt0    = 0;

  uart_rx_param d0 (
    .clk(clk), .reset(rst), .serial_in(ser0),
    .rx_data(data0), .rx_valid(val0), .rx_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0),
    .r_busy(busy0)
  );

  uart_rx_param #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .PARITY(1)
  ) d1 (
    .clk(clk), .reset(rst), .serial_in(ser1),
    .rx_data(data1), .rx_valid(val1), .rx_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1),
    .r_busy(busy1)
  );

  uart_rx_param #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2)
  ) d2 (
    .clk(clk), .reset(rst), .serial_in(ser2),
    .rx_data(data2), .rx_valid(val2), .rx_ready(rdy2),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2),
    .r_busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int k, input logic v);
    case (k)
      0: ser0 = v;
      1: ser1 = v;
      default: ser2 = v;
    endcase
  endtask

  task automatic push(
    input int k, input logic [8:0] d,
    input logic pe, input logic fe, input logic ov
  );
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(
    input int k, input logic [8:0] d,
    input logic pe, input logic fe, input logic ov
  );
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_checks++;
      $display("FAIL unexpected_frame inst%0d: got data %0h expected none",
               k, d);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("inst%0d_data", k), 32'(d), 32'(e.d));
      check($sformatf("inst%0d_parity_err", k), 32'(pe), 32'(e.pe));
      check($sformatf("inst%0d_frame_err", k), 32'(fe), 32'(e.fe));
      check($sformatf("inst%0d_overrun", k), 32'(ov), 32'(e.ov));
    end
  endtask

  // One frame: start, nb data bits LSB first, optional parity, ns stops.
  // A low stop bit is held low only past mid-bit so the line recovers.
  task automatic send(
    input int k, input logic [8:0] d, input int nb,
    input int par, input bit pflip, input int ns,
    input bit stop_low, input int idle_bits
  );
    int   cpb;
    logic p;
    cpb = (k == 0) ? 868 : 16;
    set_line(k, 1'b0);
    tick(cpb);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      set_line(k, d[i]);
      p = p ^ d[i];
      tick(cpb);
    end
    if (par != 0) begin
      if (par == 2) p = ~p;
      set_line(k, p ^ pflip);
      tick(cpb);
    end
    for (int i = 0; i < ns; i++) begin
      if (stop_low) begin
        set_line(k, 1'b0);
        tick(cpb / 2 + cpb / 8);
        set_line(k, 1'b1);
        tick(cpb - cpb / 2 - cpb / 8);
      end else begin
        set_line(k, 1'b1);
        tick(cpb);
      end
    end
    set_line(k, 1'b1);
    tick(cpb * idle_bits);
  endtask

  always @(negedge clk) begin
    if (val0) vcnt0++;
    if (busy0) bcnt0++;
    if (val0 && rdy0) pop_cmp(0, {1'b0, data0}, pe0, fe0, ov0);
    if (val1 && rdy1) pop_cmp(1, {1'b0, data1}, pe1, fe1, ov1);
    if (val2 && rdy2) pop_cmp(2, {2'b0, data2}, pe2, fe2, ov2);
  end

  initial begin
    clk = 0; rst = 1;
    ser0 = 1; ser1 = 1; ser2 = 1;
    rdy0 = 1; rdy1 = 1; rdy2 = 1;
    tick(3);
    check("rst_rx_data", 32'(data0), 0);
    check("rst_rx_valid", 32'(val0), 0);
    check("rst_parity_err", 32'(pe0), 0);
    check("rst_frame_err", 32'(fe0), 0);
    check("rst_overrun", 32'(ov0), 0);
    check("rst_r_busy", 32'(busy0), 0);
    rst = 0;
    tick(5);

    // 8N1 clean frame
    vcnt0 = 0;
    push(0, 9'h0A5, 0, 0, 0);
    send(0, 9'h0A5, 8, 0, 0, 1, 0, 1);
    check("t1_valid_cycles", 32'(vcnt0), 1);
    check("t1_busy_after", 32'(busy0), 0);

    // short low glitch is a false start
    bcnt0 = 0;
    set_line(0, 1'b0);
    tick(300);
    set_line(0, 1'b1);
    tick(700);
    check("t2_busy_len_ok", 32'(bcnt0 >= 430 && bcnt0 <= 440), 1);
    check("t2_busy_after", 32'(busy0), 0);
    check("t2_no_valid", 32'(vcnt0), 1);

    // low stop bit, then clean frame
    push(0, 9'h03C, 0, 1, 0);
    send(0, 9'h03C, 8, 0, 0, 1, 1, 1);
    push(0, 9'h03D, 0, 0, 0);
    send(0, 9'h03D, 8, 0, 0, 1, 0, 1);

    // even parity: wrong bit then right bit
    push(1, 9'h05A, 1, 0, 0);
    send(1, 9'h05A, 8, 1, 1, 1, 0, 1);
    push(1, 9'h05A, 0, 0, 0);
    send(1, 9'h05A, 8, 1, 0, 1, 0, 1);

    // 7 data, odd parity, 2 stops
    push(2, 9'h055, 0, 0, 0);
    send(2, 9'h055, 7, 2, 0, 2, 0, 1);

    // overrun with back-to-back frames
    rdy1 = 0;
    send(1, 9'h011, 8, 1, 0, 1, 0, 0);
    send(1, 9'h022, 8, 1, 0, 1, 0, 1);
    check("t5_valid_held", 32'(val1), 1);
    check("t5_data", 32'(data1), 32'h22);
    check("t5_overrun", 32'(ov1), 1);
    push(1, 9'h022, 0, 0, 1);
    rdy1 = 1;
    tick(1);
    rdy1 = 0;
    check("t5_valid_clr", 32'(val1), 0);
    check("t5_overrun_clr", 32'(ov1), 0);
    rdy1 = 1;

    // reset during data bit 3
    set_line(1, 1'b0);
    tick(16);
    set_line(1, 1'b1);
    tick(48 + 8);
    rst = 1;
    tick(2);
    check("t6_rx_data", 32'(data1), 0);
    check("t6_rx_valid", 32'(val1), 0);
    check("t6_parity_err", 32'(pe1), 0);
    check("t6_frame_err", 32'(fe1), 0);
    check("t6_overrun", 32'(ov1), 0);
    check("t6_r_busy", 32'(busy1), 0);
    rst = 0;
    tick(48);
    push(1, 9'h0C3, 0, 0, 0);
    send(1, 9'h0C3, 8, 1, 0, 1, 0, 1);

    tick(20);
    check("sb_drain_0", 32'(q0.size()), 0);
    check("sb_drain_1", 32'(q1.size()), 0);
    check("sb_drain_2", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
